// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: round-robin frame scheduler that shares one Mac_TX between
// N_REQ frame sources. It picks a source, triggers the MAC, streams the source
// bytes against Data_Strobe, marks the last byte and reports completion.
module mac_tx_arbiter #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned LEN_W    = 14,
    parameter int unsigned MAX_LEN  = 9000,
    parameter int unsigned BUSY_TMO = 16
) (
    input  logic                   clk,
    input  logic                   Reset_n_i,
    input  logic [N_REQ-1:0]       Req_i,
    input  logic [N_REQ*LEN_W-1:0] Len_flat_i,
    input  logic [N_REQ*8-1:0]     Data_flat_i,
    output logic [N_REQ-1:0]       Rd_o,
    output logic [N_REQ-1:0]       Done_o,
    output logic [N_REQ-1:0]       Err_o,
    output logic                   Trig_o,
    output logic [7:0]             Mac_Data_o,
    output logic                   Last_byte_o,
    input  logic                   Data_Strobe_i,
    input  logic                   Busy_i,
    output logic [N_REQ-1:0]       Grant_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMO_W = $clog2(BUSY_TMO + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GRANT     = 3'd1;
    localparam logic [2:0] S_TRIG      = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_STREAM    = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic             trig_q, trig_d;
    logic             fin_err;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand;
    logic [LEN_W-1:0] len_sel;
    logic [LEN_W-1:0] len_eff;
    logic [7:0]       data_sel;
    logic             stream_c;
    logic             last_c;

    // Round-robin pick: first pending request after the last granted index
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
            if (!sel_found && Req_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Length of the selected source, clamped to the largest legal payload
    always_comb begin
        len_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                len_sel = Len_flat_i[i*LEN_W +: LEN_W];
            end
        end
        len_eff = (len_sel > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_sel;
    end

    // Byte mux from the granted source
    always_comb begin
        data_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (g_q == IDX_W'(i)) begin
                data_sel = Data_flat_i[i*8 +: 8];
            end
        end
    end

    // A strobe can arrive while still waiting for Busy, so both states move bytes
    assign stream_c    = (state_q == S_WAIT_BUSY) || (state_q == S_STREAM);
    assign last_c      = stream_c && Data_Strobe_i && (cnt_q == len_q - LEN_W'(1));
    assign Rd_o        = (stream_c && Data_Strobe_i) ? grant_q : '0;
    assign Mac_Data_o  = stream_c ? data_sel : 8'd0;
    assign Last_byte_o = last_c;
    assign Trig_o      = trig_q;
    assign Grant_o     = grant_q;
    assign Done_o      = done_q;
    assign Err_o       = err_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        grant_d = grant_q;
        fin_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((Req_i != '0) && !Busy_i) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (sel_found) begin
                    g_d     = sel_idx;
                    ptr_d   = sel_idx;
                    len_d   = len_eff;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    grant_d = N_REQ'(1) << sel_idx;
                    if (len_eff == '0) begin
                        state_d = S_DONE;
                        fin_err = 1'b1;
                    end else begin
                        state_d = S_TRIG;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TRIG: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (Data_Strobe_i) begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = last_c ? S_WAIT_IDLE : S_STREAM;
                end else if (!Busy_i) begin
                    if (tmo_q == TMO_W'(BUSY_TMO - 1)) begin
                        state_d = S_DONE;
                        fin_err = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            S_STREAM: begin
                if (Data_Strobe_i) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_c) begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (!Busy_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        trig_d = (state_d == S_TRIG);
        done_d = (state_d == S_DONE) ? grant_d : '0;
        err_d  = fin_err ? grant_d : '0;
    end

    // State and output registers; reset leaves the pointer so source 0 wins first
    always_ff @(posedge clk) begin
        if (!Reset_n_i) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            len_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            trig_q  <= trig_d;
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: directed bench with a Mac_TX responder, byte sources and
// an expected-byte scoreboard for mac_tx_arbiter.
module tb_mac_tx_arbiter;

    logic        clk;
    logic        Reset_n_i;
    logic [1:0]  Req_i;
    logic [27:0] Len_flat_i;
    logic [15:0] Data_flat_i;
    logic [1:0]  Rd_o;
    logic [1:0]  Done_o;
    logic [1:0]  Err_o;
    logic        Trig_o;
    logic [7:0]  Mac_Data_o;
    logic        Last_byte_o;
    logic        Data_Strobe_i;
    logic        Busy_i;
    logic [1:0]  Grant_o;

    mac_tx_arbiter #(
        .N_REQ   (2),
        .LEN_W   (14),
        .MAX_LEN (9000),
        .BUSY_TMO(16)
    ) dut (
        .clk          (clk),
        .Reset_n_i    (Reset_n_i),
        .Req_i        (Req_i),
        .Len_flat_i   (Len_flat_i),
        .Data_flat_i  (Data_flat_i),
        .Rd_o         (Rd_o),
        .Done_o       (Done_o),
        .Err_o        (Err_o),
        .Trig_o       (Trig_o),
        .Mac_Data_o   (Mac_Data_o),
        .Last_byte_o  (Last_byte_o),
        .Data_Strobe_i(Data_Strobe_i),
        .Busy_i       (Busy_i),
        .Grant_o      (Grant_o)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [1:0] rd;
    } exp_t;

    exp_t exp_q[$];

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // bench-side MAC/source model state
    bit   mac_en = 1'b1;
    bit   mac_rst = 1'b0;
    int   gap_at = -1;
    int   gap_len = 0;
    int   tail_len = 4;
    int   cyc = 0;
    int   src_pos[2];
    int   exp_pos[2];
    int   rd_cnt[2];
    int   last_cnt = 0;
    int   trig_cnt = 0;
    int   trig_cyc = 0;
    int   trig_wide_err = 0;
    int   byte_err = 0;
    logic [1:0] trig_grant = 2'b00;

    function automatic logic [7:0] src_byte(input int s, input int p);
        return 8'(p * 13 + s * 101 + 7);
    endfunction

    // Mac_TX responder and byte sources: drive on negedge, observe 1 ns later
    initial begin : mac_model
        int   m_st;
        int   gap_left;
        int   tail_left;
        int   frame_bytes;
        bit   gap_done;
        logic prev_trig;
        logic prev_last;
        logic trig_was;
        logic [1:0] prev_rd;
        exp_t e;
        m_st = 0; gap_left = 0; tail_left = 0; frame_bytes = 0; gap_done = 1'b0;
        prev_trig = 1'b0; prev_last = 1'b0; trig_was = 1'b0; prev_rd = 2'b00;
        src_pos[0] = 0; src_pos[1] = 0; rd_cnt[0] = 0; rd_cnt[1] = 0;
        Busy_i = 1'b0;
        Data_Strobe_i = 1'b0;
        Data_flat_i = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int s = 0; s < 2; s++) begin
                if (prev_rd[s]) src_pos[s]++;
                Data_flat_i[s*8 +: 8] = src_byte(s, src_pos[s]);
            end
            if (mac_rst) begin
                m_st = 0;
                Busy_i = 1'b0;
                Data_Strobe_i = 1'b0;
            end else begin
                case (m_st)
                    0: if (prev_trig && mac_en) begin
                        Busy_i = 1'b1;
                        m_st = 1;
                    end
                    1: begin
                        Data_Strobe_i = 1'b1;
                        frame_bytes = 0;
                        gap_done = 1'b0;
                        gap_left = 0;
                        m_st = 2;
                    end
                    2: begin
                        if (prev_last) begin
                            Data_Strobe_i = 1'b0;
                            tail_left = tail_len;
                            m_st = 3;
                        end else if (gap_left > 0) begin
                            Data_Strobe_i = 1'b0;
                            gap_left--;
                        end else if (frame_bytes == gap_at && !gap_done) begin
                            Data_Strobe_i = 1'b0;
                            gap_done = 1'b1;
                            gap_left = gap_len - 1;
                        end else begin
                            Data_Strobe_i = 1'b1;
                        end
                    end
                    default: begin
                        if (tail_left > 0) begin
                            tail_left--;
                        end else begin
                            Busy_i = 1'b0;
                            m_st = 0;
                        end
                    end
                endcase
            end
            #1;
            prev_trig = Trig_o;
            if (Trig_o) begin
                trig_cnt++;
                trig_cyc = cyc;
                trig_grant = Grant_o;
                if (trig_was) trig_wide_err++;
            end
            trig_was = Trig_o;
            prev_last = Last_byte_o && Data_Strobe_i;
            prev_rd = Rd_o;
            for (int s = 0; s < 2; s++) if (Rd_o[s]) rd_cnt[s]++;
            if (Last_byte_o) last_cnt++;
            if (Data_Strobe_i && m_st == 2) begin
                frame_bytes++;
                if (exp_q.size() == 0) begin
                    byte_err++;
                end else begin
                    e = exp_q.pop_front();
                    if (Mac_Data_o !== e.data || Last_byte_o !== e.last || Rd_o !== e.rd)
                        byte_err++;
                end
            end else if (Rd_o != 2'b00 || Last_byte_o) begin
                byte_err++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic set_len(input int s, input int len);
        Len_flat_i[s*14 +: 14] = 14'(len);
    endtask

    // Scoreboard: expected bytes of one frame, queued in grant order
    task automatic push_frame(input int s, input int len);
        exp_t e;
        int le;
        le = (len > 9000) ? 9000 : len;
        for (int p = 0; p < le; p++) begin
            e.data = src_byte(s, exp_pos[s] + p);
            e.last = (p == le - 1);
            e.rd   = 2'(1 << s);
            exp_q.push_back(e);
        end
        exp_pos[s] += le;
    endtask

    task automatic wait_done(input int budget, input bit drop,
                             output logic [1:0] d, output logic [1:0] e, output int c);
        d = 2'b00; e = 2'b00; c = 0;
        for (int i = 0; i < budget && d == 2'b00; i++) begin
            tick();
            if (Done_o != 2'b00) begin
                d = Done_o;
                e = Err_o;
                c = cyc;
                chk("busy_low_at_done", 32'(Busy_i), 32'd0);
                if (drop) Req_i = 2'b00;
            end
        end
        chk("done_seen", 32'(d != 2'b00), 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, 32'(Grant_o), 32'd0);
        chk({tag, "_trig"},  32'(Trig_o), 32'd0);
        chk({tag, "_done"},  32'(Done_o), 32'd0);
        chk({tag, "_err"},   32'(Err_o), 32'd0);
        chk({tag, "_rd"},    32'(Rd_o), 32'd0);
        chk({tag, "_last"},  32'(Last_byte_o), 32'd0);
        chk({tag, "_data"},  32'(Mac_Data_o), 32'd0);
    endtask

    initial begin : stimulus
        logic [1:0] d;
        logic [1:0] e;
        int c;
        int c0;
        int t0;
        int r0;
        int r1;
        int l0;
        int b0;
        int k;

        exp_pos[0] = 0; exp_pos[1] = 0;
        Reset_n_i = 1'b0;
        Req_i = 2'b00;
        Len_flat_i = '0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        Reset_n_i = 1'b1;
        tick();

        // single frame from source 0
        t0 = trig_cnt; r0 = rd_cnt[0]; l0 = last_cnt; b0 = byte_err;
        set_len(0, 64);
        push_frame(0, 64);
        Req_i = 2'b01;
        wait_done(400, 1'b1, d, e, c);
        chk("t1_done_src", 32'(d), 32'd1);
        chk("t1_err", 32'(e), 32'd0);
        chk("t1_trig_pulses", 32'(trig_cnt - t0), 32'd1);
        chk("t1_rd_count", 32'(rd_cnt[0] - r0), 32'd64);
        chk("t1_last_count", 32'(last_cnt - l0), 32'd1);
        chk("t1_byte_err", 32'(byte_err - b0), 32'd0);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // both sources pending: strict alternation starting at source 0 after reset
        Reset_n_i = 1'b0;
        repeat (2) tick();
        Reset_n_i = 1'b1;
        t0 = trig_cnt; b0 = byte_err;
        set_len(0, 60);
        set_len(1, 60);
        for (int f = 0; f < 4; f++) push_frame(f % 2, 60);
        Req_i = 2'b11;
        for (int f = 0; f < 4; f++) begin
            wait_done(400, f == 3, d, e, c);
            chk("t2_grant_order", 32'(d), (f % 2 == 0) ? 32'd1 : 32'd2);
            chk("t2_err", 32'(e), 32'd0);
        end
        chk("t2_trig_pulses", 32'(trig_cnt - t0), 32'd4);
        chk("t2_trig_single_cycle", 32'(trig_wide_err), 32'd0);
        chk("t2_byte_err", 32'(byte_err - b0), 32'd0);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // zero-length frame on source 1: error completion, no trigger
        tick();
        t0 = trig_cnt;
        set_len(1, 0);
        Req_i = 2'b10;
        c0 = cyc;
        wait_done(20, 1'b1, d, e, c);
        chk("t3_done_src", 32'(d), 32'd2);
        chk("t3_err", 32'(e), 32'd2);
        chk("t3_latency", 32'(c - c0), 32'd2);
        chk("t3_no_trig", 32'(trig_cnt - t0), 32'd0);

        // MAC never answers: timeout after 16 cycles in WAIT_BUSY
        tick();
        mac_en = 1'b0;
        t0 = trig_cnt;
        set_len(0, 10);
        Req_i = 2'b01;
        wait_done(100, 1'b1, d, e, c);
        chk("t4_done_src", 32'(d), 32'd1);
        chk("t4_err", 32'(e), 32'd1);
        chk("t4_trig_to_done", 32'(c - trig_cyc), 32'd17);
        chk("t4_trig_pulses", 32'(trig_cnt - t0), 32'd1);
        mac_en = 1'b1;
        tick();
        r1 = rd_cnt[1]; b0 = byte_err;
        set_len(1, 5);
        push_frame(1, 5);
        Req_i = 2'b10;
        wait_done(200, 1'b1, d, e, c);
        chk("t4_next_src", 32'(d), 32'd2);
        chk("t4_next_err", 32'(e), 32'd0);
        chk("t4_next_rd", 32'(rd_cnt[1] - r1), 32'd5);
        chk("t4_next_byte_err", 32'(byte_err - b0), 32'd0);

        // oversize frame clamped to 9000 bytes with a 3-cycle strobe gap
        tick();
        r0 = rd_cnt[0]; l0 = last_cnt; b0 = byte_err;
        gap_at = 4000;
        gap_len = 3;
        set_len(0, 12000);
        push_frame(0, 12000);
        Req_i = 2'b01;
        wait_done(12000, 1'b1, d, e, c);
        gap_at = -1;
        chk("t5_done_src", 32'(d), 32'd1);
        chk("t5_err", 32'(e), 32'd0);
        chk("t5_rd_count", 32'(rd_cnt[0] - r0), 32'd9000);
        chk("t5_last_count", 32'(last_cnt - l0), 32'd1);
        chk("t5_byte_err", 32'(byte_err - b0), 32'd0);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // reset during streaming at byte 30, then a fresh grant with Req held
        tick();
        r1 = rd_cnt[1]; b0 = byte_err;
        set_len(1, 100);
        push_frame(1, 100);
        Req_i = 2'b10;
        k = 0;
        while (rd_cnt[1] - r1 < 30 && k < 300) begin
            tick();
            k++;
        end
        chk("t6_reached_byte30", 32'(rd_cnt[1] - r1), 32'd30);
        Reset_n_i = 1'b0;
        mac_rst = 1'b1;
        tick();
        chk_idle_outputs("t6_reset");
        repeat (2) tick();
        chk("t6_no_done_in_reset", 32'(Done_o), 32'd0);
        chk("t6_rd_after_abort", 32'(rd_cnt[1] - r1), 32'd30);
        chk("t6_partial_byte_err", 32'(byte_err - b0), 32'd0);
        exp_q.delete();
        exp_pos[1] = src_pos[1];
        push_frame(1, 100);
        Reset_n_i = 1'b1;
        mac_rst = 1'b0;
        wait_done(400, 1'b1, d, e, c);
        chk("t6_done_src", 32'(d), 32'd2);
        chk("t6_err", 32'(e), 32'd0);
        chk("t6_regrant", 32'(trig_grant), 32'd2);
        chk("t6_rd_total", 32'(rd_cnt[1] - r1), 32'd130);
        chk("t6_byte_err", 32'(byte_err - b0), 32'd0);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
